cmd_line_assembler: RTL and testbench

CMD_LINE_ASSEMBLER -- requirements
Module: cmd_line_assembler

---
 rtl/cmd_line_assembler_pkg.sv | 28 ++
 rtl/cmd_line_assembler_ascii_classify.sv | 16 +
 rtl/cmd_line_assembler.sv | 133 +++++++++++++
 tb/tb_cmd_line_assembler.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_line_assembler_pkg.sv
// Shared definitions for the command-line assembler and the shop that consumes its words:
// word geometry, ASCII control codes, FSM state encodings and the byte-class bundle.
package cmd_line_assembler_pkg;

    localparam int I_A_NUM_ASCII_CHARS = 7;
    localparam int I_A_NUM_BITS        = I_A_NUM_ASCII_CHARS * 8;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EMIT    = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

    typedef struct packed {
        logic printable;
        logic terminator;
        logic backspace;
    } byte_class_t;

endpackage

// File: rtl/cmd_line_assembler_ascii_classify.sv
// Purely combinational byte classifier: each received byte is printable, a line
// terminator, a backspace, or none of these (and then ignored by the assembler).
module ascii_classify
    import cmd_line_assembler_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       printable_o,
    output logic       terminator_o,
    output logic       backspace_o
);

    assign printable_o  = (byte_i >= ASCII_SPACE) && (byte_i <= ASCII_TILDE);
    assign terminator_o = (byte_i == ASCII_CR) || (byte_i == ASCII_LF);
    assign backspace_o  = (byte_i == ASCII_BS) || (byte_i == ASCII_DEL);

endmodule

// File: rtl/cmd_line_assembler.sv
// Collects terminal keystrokes into a right-justified ASCII command word and strobes
// it to the shop, with line editing, overflow discard and a post-word holdoff.
module cmd_line_assembler #(
    parameter int I_A_NUM_ASCII_CHARS = cmd_line_assembler_pkg::I_A_NUM_ASCII_CHARS,
    parameter int I_A_NUM_BITS        = I_A_NUM_ASCII_CHARS * 8,
    parameter int HOLDOFF_CYCLES      = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_rx_valid,
    input  logic [7:0]              i_rx_data,
    output logic                    o_rx_ready,
    output logic [I_A_NUM_BITS-1:0] o_a,
    output logic                    o_rdy,
    output logic                    o_err_overflow,
    output logic [2:0]              o_len
);

    import cmd_line_assembler_pkg::*;

    localparam logic [2:0] MAX_LEN   = 3'(I_A_NUM_ASCII_CHARS);
    localparam int         CNT_W     = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int         HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

    state_e                  state_q, state_d;
    logic [I_A_NUM_BITS-1:0] line_q,  line_d;
    logic [I_A_NUM_BITS-1:0] a_q,     a_d;
    logic [2:0]              len_q,   len_d;
    logic [CNT_W-1:0]        hold_q,  hold_d;
    logic                    err_q,   err_d;

    byte_class_t cls;
    logic        rx_accept;

    ascii_classify u_classify (
        .byte_i       (i_rx_data),
        .printable_o  (cls.printable),
        .terminator_o (cls.terminator),
        .backspace_o  (cls.backspace)
    );

    // Gating with i_reset keeps the handshake closed for the whole reset cycle.
    assign o_rx_ready     = !i_reset && ((state_q == ST_COLLECT) || (state_q == ST_DISCARD));
    assign rx_accept      = i_rx_valid && o_rx_ready;
    assign o_rdy          = (state_q == ST_EMIT);
    assign o_err_overflow = err_q;
    assign o_a            = a_q;
    assign o_len          = len_q;

    always_comb begin
        // NOTE: every next-state signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        line_d  = line_q;
        a_d     = a_q;
        len_d   = len_q;
        hold_d  = hold_q;
        err_d   = 1'b0;

        unique case (state_q)
            ST_COLLECT: begin
                if (rx_accept) begin
                    if (cls.printable) begin
                        if (len_q < MAX_LEN) begin
                            line_d = {line_q[I_A_NUM_BITS-9:0], i_rx_data};
                            len_d  = len_q + 3'd1;
                        end else begin
                            line_d  = '0;
                            len_d   = '0;
                            err_d   = 1'b1;
                            state_d = ST_DISCARD;
                        end
                    end else if (cls.backspace) begin
                        if (len_q != '0) begin
                            line_d = line_q >> 8;
                            len_d  = len_q - 3'd1;
                        end
                    end else if (cls.terminator && (len_q != '0)) begin
                        // Empty-line terminators are dropped, so CR LF yields a single word.
                        a_d     = line_q;
                        line_d  = '0;
                        len_d   = '0;
                        state_d = ST_EMIT;
                    end
                end
            end

            ST_EMIT: begin
                if (HOLDOFF_CYCLES == 0) begin
                    state_d = ST_COLLECT;
                end else begin
                    hold_d  = CNT_W'(HOLD_LOAD);
                    state_d = ST_HOLDOFF;
                end
            end

            ST_HOLDOFF: begin
                if (hold_q == '0) begin
                    state_d = ST_COLLECT;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end

            ST_DISCARD: begin
                if (rx_accept && cls.terminator) begin
                    state_d = ST_COLLECT;
                end
            end

            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (i_reset) begin
            state_q <= ST_COLLECT;
            line_q  <= '0;
            a_q     <= '0;
            len_q   <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            a_q     <= a_d;
            len_q   <= len_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cmd_line_assembler.sv
// Directed self-checking bench for cmd_line_assembler: word assembly, editing,
// overflow discard, holdoff handshake and reset behaviour.
module tb_cmd_line_assembler;

    logic        i_clk;
    logic        i_reset;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_rx_ready;
    logic [55:0] o_a;
    logic        o_rdy;
    logic        o_err_overflow;
    logic [2:0]  o_len;

    int total = 0;
    int bad   = 0;
    int rdy_cnt  = 0;
    int ovf_cnt  = 0;
    int both_cnt = 0;

    cmd_line_assembler #(
        .I_A_NUM_ASCII_CHARS (7),
        .I_A_NUM_BITS        (56),
        .HOLDOFF_CYCLES      (2)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_rx_valid     (i_rx_valid),
        .i_rx_data      (i_rx_data),
        .o_rx_ready     (o_rx_ready),
        .o_a            (o_a),
        .o_rdy          (o_rdy),
        .o_err_overflow (o_err_overflow),
        .o_len          (o_len)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Strobe counters sample the value held during each cycle, just before its closing edge.
    always @(posedge i_clk) begin
        if (o_rdy) rdy_cnt++;
        if (o_err_overflow) ovf_cnt++;
        if (o_rdy && o_err_overflow) both_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the byte was accepted.
    task automatic send(input logic [7:0] b);
        int n = 0;
        while (!o_rx_ready && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_rx_ready) check("ready_timeout", {63'd0, o_rx_ready}, 64'd1);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    int base_rdy;
    int base_ovf;
    int low_cnt;
    int pulses;
    int idx;
    int cyc;
    logic acc;
    logic [7:0] stream [5];

    initial begin
        i_reset    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;

        // Reset state.
        repeat (3) @(negedge i_clk);
        check("rst_ready", {63'd0, o_rx_ready}, 64'd0);
        check("rst_a", {8'd0, o_a}, 64'd0);
        check("rst_rdy", {63'd0, o_rdy}, 64'd0);
        check("rst_ovf", {63'd0, o_err_overflow}, 64'd0);
        check("rst_len", {61'd0, o_len}, 64'd0);
        i_reset = 1'b0;
        #1;
        check("post_rst_ready", {63'd0, o_rx_ready}, 64'd1);
        @(negedge i_clk);

        // "Login" CR: one-cycle strobe the cycle after CR, then 2 holdoff cycles.
        base_rdy = rdy_cnt;
        send("L"); send("o"); send("g"); send("i"); send("n");
        check("login_len", {61'd0, o_len}, 64'd5);
        send(8'h0D);
        check("login_rdy", {63'd0, o_rdy}, 64'd1);
        check("login_a", {8'd0, o_a}, 64'h0000_4C6F_6769_6E);
        check("login_len0", {61'd0, o_len}, 64'd0);
        check("login_ready_emit", {63'd0, o_rx_ready}, 64'd0);
        @(negedge i_clk);
        check("login_rdy_drop", {63'd0, o_rdy}, 64'd0);
        check("login_ready_h1", {63'd0, o_rx_ready}, 64'd0);
        @(negedge i_clk);
        check("login_ready_h2", {63'd0, o_rx_ready}, 64'd0);
        @(negedge i_clk);
        check("login_ready_back", {63'd0, o_rx_ready}, 64'd1);
        check("login_pulses", rdy_cnt - base_rdy, 64'd1);

        // "Us2" BS "1" CR with o_len tracking.
        send("U");   check("us_len1", {61'd0, o_len}, 64'd1);
        send("s");   check("us_len2", {61'd0, o_len}, 64'd2);
        send("2");   check("us_len3", {61'd0, o_len}, 64'd3);
        send(8'h08); check("us_len_bs", {61'd0, o_len}, 64'd2);
        send("1");   check("us_len3b", {61'd0, o_len}, 64'd3);
        send(8'h0D); check("us_len0", {61'd0, o_len}, 64'd0);
        check("us_a", {8'd0, o_a}, 64'h0000_0000_5573_31);
        idle(4);

        // "AddItemX" CR: overflow on the 8th char, no word, o_a unchanged.
        base_rdy = rdy_cnt;
        base_ovf = ovf_cnt;
        send("A"); send("d"); send("d"); send("I"); send("t"); send("e"); send("m");
        check("ovf_len7", {61'd0, o_len}, 64'd7);
        send("X");
        check("ovf_pulse", {63'd0, o_err_overflow}, 64'd1);
        check("ovf_len0", {61'd0, o_len}, 64'd0);
        check("ovf_discard_ready", {63'd0, o_rx_ready}, 64'd1);
        @(negedge i_clk);
        check("ovf_pulse_drop", {63'd0, o_err_overflow}, 64'd0);
        send("Z");
        check("discard_len", {61'd0, o_len}, 64'd0);
        send(8'h0D);
        check("discard_no_rdy", {63'd0, o_rdy}, 64'd0);
        idle(3);
        check("ovf_rdy_count", rdy_cnt - base_rdy, 64'd0);
        check("ovf_count", ovf_cnt - base_ovf, 64'd1);
        check("ovf_a_kept", {8'd0, o_a}, 64'h0000_0000_5573_31);
        send("B"); send("u"); send("y"); send(8'h0D);
        check("buy_rdy", {63'd0, o_rdy}, 64'd1);
        check("buy_a", {8'd0, o_a}, 64'h0000_0000_4275_79);
        idle(4);

        // "Adm" CR LF with valid held high.
        stream[0] = "A"; stream[1] = "d"; stream[2] = "m";
        stream[3] = 8'h0D; stream[4] = 8'h0A;
        base_rdy = rdy_cnt;
        low_cnt = 0; pulses = 0; idx = 0; cyc = 0;
        i_rx_valid = 1'b1;
        while (idx < 5 && cyc < 40) begin
            i_rx_data = stream[idx];
            acc = o_rx_ready;
            @(negedge i_clk);
            cyc++;
            if (acc) idx++;
            if (!o_rx_ready) low_cnt++;
            if (o_rdy) pulses++;
        end
        i_rx_valid = 1'b0;
        check("adm_all_accepted", idx, 64'd5);
        check("adm_low_cycles", low_cnt, 64'd3);
        check("adm_pulses", pulses, 64'd1);
        check("adm_a", {8'd0, o_a}, 64'h0000_0000_4164_6D);
        check("adm_lf_len", {61'd0, o_len}, 64'd0);
        idle(4);
        check("adm_rdy_count", rdy_cnt - base_rdy, 64'd1);

        // Exactly seven characters is still a valid word.
        send("A"); send("B"); send("C"); send("D"); send("E"); send("F"); send("G");
        send(8'h0D);
        check("full_rdy", {63'd0, o_rdy}, 64'd1);
        check("full_a", {8'd0, o_a}, 64'h0041_4243_4445_4647);
        idle(4);

        // Reset mid-line discards the partial line with no strobe.
        base_rdy = rdy_cnt;
        send("U"); send("s");
        check("mid_len2", {61'd0, o_len}, 64'd2);
        i_reset = 1'b1;
        #1;
        check("mid_rst_ready", {63'd0, o_rx_ready}, 64'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        check("mid_len0", {61'd0, o_len}, 64'd0);
        check("mid_ready", {63'd0, o_rx_ready}, 64'd1);
        check("mid_a_cleared", {8'd0, o_a}, 64'd0);
        @(negedge i_clk);
        send("1"); send(8'h0D);
        check("mid_a", {8'd0, o_a}, 64'h31);
        idle(4);
        check("mid_rdy_count", rdy_cnt - base_rdy, 64'd1);

        // Empty line, backspace/DEL on an empty buffer, and an ignored control byte.
        base_rdy = rdy_cnt;
        base_ovf = ovf_cnt;
        send(8'h0D); check("empty_cr_rdy", {63'd0, o_rdy}, 64'd0);
        send(8'h08); check("empty_bs_len", {61'd0, o_len}, 64'd0);
        send(8'h7F); check("empty_del_len", {61'd0, o_len}, 64'd0);
        send(8'h01); check("ctrl_ignored_len", {61'd0, o_len}, 64'd0);
        send("Q");   send(8'h1B);
        check("esc_ignored_len", {61'd0, o_len}, 64'd1);
        send(8'h7F); check("del_len", {61'd0, o_len}, 64'd0);
        idle(3);
        check("empty_rdy_count", rdy_cnt - base_rdy, 64'd0);
        check("empty_ovf_count", ovf_cnt - base_ovf, 64'd0);

        // Reset while in EMIT clears o_a and ends the strobe.
        send("Q"); send(8'h0D);
        check("emit_rdy", {63'd0, o_rdy}, 64'd1);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("emit_rst_rdy", {63'd0, o_rdy}, 64'd0);
        check("emit_rst_a", {8'd0, o_a}, 64'd0);
        i_reset = 1'b0;
        #1;
        check("emit_rst_ready", {63'd0, o_rx_ready}, 64'd1);
        idle(2);

        check("never_both", both_cnt, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
